// File: rtl/sdp_ram_pkg.sv
// Shared encodings and parameter-legality helpers for the initialising dual-port RAM.
package sdp_ram_pkg;

    typedef enum logic [1:0] {
        INIT_ADDR  = 2'd0,
        INIT_CONST = 2'd1,
        INIT_SEED  = 2'd2,
        INIT_ZERO  = 2'd3
    } init_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned DATA_W_MIN = 8;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Inferred simple dual-port array with read-first semantics and a 1- or 2-stage read pipeline.
module sdp_ram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_vld
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        // Single stage: array read lands directly in the reset output register.
        always_comb begin
            dout_d = dout_q;
            if (i_re) begin
                dout_d = mem[i_raddr];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                vld_q  <= i_re;
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_vld_q;

        // Un-reset array output register keeps the read path RAM-macro friendly.
        always_ff @(posedge i_clk) begin
            if (i_re) begin
                rd_data_q <= mem[i_raddr];
            end
        end

        always_comb begin
            dout_d = dout_q;
            if (rd_vld_q) begin
                dout_d = rd_data_q;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_vld_q <= 1'b0;
                dout_q   <= '0;
                vld_q    <= 1'b0;
            end else begin
                rd_vld_q <= i_re;
                dout_q   <= dout_d;
                vld_q    <= rd_vld_q;
            end
        end
    end

    assign o_dout     = dout_q;
    assign o_dout_vld = vld_q;

endmodule

// File: rtl/sdp_ram_init.sv
// Dual-port RAM wrapper: fill engine FSM, pattern generator and write-port arbitration.
module sdp_ram_init
    import sdp_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned AUTO_INIT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_start,
    input  logic [1:0]        i_init_mode,
    input  logic [DATA_W-1:0] i_init_val,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_vld,
    output logic              o_busy,
    output logic              o_init_done,
    output logic              o_wr_drop
);

    if (!rd_lat_legal(RD_LAT) || (DATA_W < DATA_W_MIN)) begin : g_param_err
        $error("sdp_ram_init: RD_LAT must be 1 or 2 and DATA_W at least 8");
    end

    localparam bit AUTO = (AUTO_INIT != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    init_mode_e        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              wr_drop_q, wr_drop_d;
    logic              start_c;

    logic [DATA_W-1:0] fill_data_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Next-state, fill counter and sticky-done logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        done_d    = done_q;
        wr_drop_d = i_wr_en && (state_q != ST_READY);
        start_c   = ((state_q == ST_IDLE) && (AUTO || i_init_start)) ||
                    ((state_q == ST_READY) && i_init_start);

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start_c) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    mode_d  = init_mode_e'(i_init_mode);
                    seed_d  = i_init_val;
                    done_d  = 1'b0;
                end
            end
            ST_FILL: begin
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= INIT_ADDR;
            seed_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Fill pattern; address is resized to the data width, seed sum wraps naturally.
    always_comb begin
        fill_data_c = '0;
        case (mode_q)
            INIT_ADDR:  fill_data_c = DATA_W'(cnt_q);
            INIT_CONST: fill_data_c = seed_q;
            INIT_SEED:  fill_data_c = seed_q + DATA_W'(cnt_q);
            default:    fill_data_c = '0;
        endcase
    end

    // The fill engine owns the write port until READY.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = i_wr_addr;
        mem_wdata_c = i_wr_data;
        if (state_q == ST_FILL) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = fill_data_c;
        end else if (state_q == ST_READY) begin
            mem_we_c = i_wr_en;
        end
    end

    sdp_ram_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (mem_we_c),
        .i_waddr    (mem_waddr_c),
        .i_wdata    (mem_wdata_c),
        .i_re       (i_rd_en),
        .i_raddr    (i_rd_addr),
        .o_dout     (o_dout),
        .o_dout_vld (o_dout_vld)
    );

    assign o_busy      = busy_q;
    assign o_init_done = done_q;
    assign o_wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_sdp_ram_init.sv
// Scoreboard bench: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream.
module tb_sdp_ram_init;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic [1:0]  init_mode = 2'd0;
    logic [31:0] init_val = 32'd0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = 10'd0;
    logic [31:0] wr_data = 32'd0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_addr = 10'd0;

    logic [31:0] dout1, dout2;
    logic        vld1, vld2, busy1, busy2, done1, done2, drop1, drop2;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdp_ram_init #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .AUTO_INIT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .i_init_mode(init_mode),
        .i_init_val(init_val), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_dout(dout1), .o_dout_vld(vld1),
        .o_busy(busy1), .o_init_done(done1), .o_wr_drop(drop1)
    );

    sdp_ram_init #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2), .AUTO_INIT(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_init_start(init_start), .i_init_mode(init_mode),
        .i_init_val(init_val), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_dout(dout2), .o_dout_vld(vld2),
        .o_busy(busy2), .o_init_done(done2), .o_wr_drop(drop2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents valid read data.
    always @(negedge clk) begin
        exp_t e;
        if (vld1) begin
            if (q1.size() == 0) begin
                check("rd_lat1_unexpected_vld", 32'(vld1), 32'd0);
            end else begin
                e = q1.pop_front();
                check("rd_lat1_data", dout1, e.data);
                check("rd_lat1_timing", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vld2) begin
            if (q2.size() == 0) begin
                check("rd_lat2_unexpected_vld", 32'(vld2), 32'd0);
            end else begin
                e = q2.pop_front();
                check("rd_lat2_data", dout2, e.data);
                check("rd_lat2_timing", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic chk_zero(input string nm);
        check({nm, "_dout1"}, dout1, 32'd0);
        check({nm, "_vld1"}, 32'(vld1), 32'd0);
        check({nm, "_busy1"}, 32'(busy1), 32'd0);
        check({nm, "_done1"}, 32'(done1), 32'd0);
        check({nm, "_drop1"}, 32'(drop1), 32'd0);
        check({nm, "_dout2"}, dout2, 32'd0);
        check({nm, "_vld2"}, 32'(vld2), 32'd0);
        check({nm, "_busy2"}, 32'(busy2), 32'd0);
        check({nm, "_done2"}, 32'(done2), 32'd0);
        check({nm, "_drop2"}, 32'(drop2), 32'd0);
    endtask

    // Drive one read (optionally with a same-cycle write), queue expectations, hold one cycle.
    task automatic rdwr(input logic [9:0] a, input logic [31:0] e,
                        input bit do_wr, input logic [31:0] wd);
        exp_t x;
        rd_en   = 1'b1;
        rd_addr = a;
        wr_en   = do_wr;
        wr_addr = a;
        wr_data = wd;
        x.data  = e;
        x.cyc   = cyc + 1;
        q1.push_back(x);
        x.cyc   = cyc + 2;
        q2.push_back(x);
        @(negedge clk);
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e);
        rdwr(a, e, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        init_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] v);
        init_start = 1'b1;
        init_mode  = m;
        init_val   = v;
    endtask

    // Follow a fill from its start event; optional dropped write and early abort.
    task automatic fill_wait(input string nm, input int drop_at, input int abort_at);
        int n;
        n = 0;
        @(negedge clk);
        init_start = 1'b0;
        init_mode  = 2'd3;
        init_val   = 32'hDEAD_0000;
        check({nm, "_busy_rise1"}, 32'(busy1), 32'd1);
        check({nm, "_busy_rise2"}, 32'(busy2), 32'd1);
        check({nm, "_done_low"}, 32'(done1), 32'd0);
        while (busy1 && n < 1100) begin
            n++;
            if (abort_at != 0 && n == abort_at) return;
            if (n == 10) init_start = 1'b1;
            if (n == 11) init_start = 1'b0;
            if (drop_at != 0 && n == drop_at) begin
                wr_en   = 1'b1;
                wr_addr = 10'd7;
                wr_data = 32'h0000_00A5;
            end
            if (drop_at != 0 && n == drop_at + 1) begin
                wr_en = 1'b0;
                check({nm, "_drop1_pulse"}, 32'(drop1), 32'd1);
                check({nm, "_drop2_pulse"}, 32'(drop2), 32'd1);
            end
            if (drop_at != 0 && n == drop_at + 2) begin
                check({nm, "_drop1_end"}, 32'(drop1), 32'd0);
            end
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 32'(n), 32'd1024);
        check({nm, "_done1"}, 32'(done1), 32'd1);
        check({nm, "_done2"}, 32'(done2), 32'd1);
        check({nm, "_busy2_low"}, 32'(busy2), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        fill_wait("auto_fill", 0, 0);
        rd(10'd0, 32'd0);
        rd(10'd5, 32'd5);
        rd(10'd1023, 32'd1023);
        idle(4);

        start(2'd2, 32'hFFFF_FFFE);
        fill_wait("seed_fill", 0, 0);
        rd(10'd1, 32'hFFFF_FFFF);
        rd(10'd3, 32'h0000_0001);
        rd(10'd0, 32'hFFFF_FFFE);
        idle(4);

        start(2'd1, 32'h0000_1234);
        fill_wait("const_fill", 500, 0);
        // First cycle after busy falls: write accepted, same-cycle read sees old data.
        rdwr(10'd7, 32'h0000_1234, 1'b1, 32'h0000_00A5);
        rd(10'd7, 32'h0000_00A5);
        rdwr(10'd20, 32'h0000_1234, 1'b1, 32'hCAFE_BABE);
        rd(10'd20, 32'hCAFE_BABE);
        idle(5);
        check("hold_dout1", dout1, 32'hCAFE_BABE);
        check("hold_dout2", dout2, 32'hCAFE_BABE);
        check("hold_drop1", 32'(drop1), 32'd0);

        start(2'd3, 32'd0);
        fill_wait("abort_fill", 0, 300);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_fill_reset");
        repeat (3) @(negedge clk);
        chk_zero("reset_hold");
        init_mode = 2'd2;
        init_val  = 32'h0000_0100;
        rst_n     = 1'b1;
        fill_wait("restart_fill", 0, 0);
        rd(10'd0, 32'h0000_0100);
        rd(10'd299, 32'h0000_022B);
        rd(10'd300, 32'h0000_022C);
        rd(10'd1023, 32'h0000_04FF);
        idle(6);

        check("drain_q1", 32'(q1.size()), 32'd0);
        check("drain_q2", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdp_ram_init.md
# sdp_ram_init

Parametrised simple dual-port RAM with a built-in initialisation engine. After reset, or on request, it fills every location with a selectable pattern at one word per cycle, then hands the write port to the user. The read port runs independently with a configurable pipelined latency and a valid strobe. It is the standard on-chip buffer/lookup memory for the datapath blocks in this design.

## Interface
- DATA_W, 32, data word width (≥ 8)
- ADDR_W, 10, address width; depth = 2**ADDR_W
- RD_LAT, 1, read latency in cycles, legal values 1 or 2
- AUTO_INIT, 1, 1 = start a fill automatically when reset is released

- i_clk, input, 1, single clock; all logic on rising edge
- i_rst_n, input, 1, asynchronous active-low reset
- i_init_start, input, 1, one-cycle pulse that starts a fill; honoured only in IDLE or READY
- i_init_mode, input, 2, fill pattern: 0 = address, 1 = constant i_init_val, 2 = i_init_val + address, 3 = zero
- i_init_val, input, DATA_W, fill constant or seed
- i_wr_en, input, 1, user write strobe
- i_wr_addr, input, ADDR_W, user write address
- i_wr_data, input, DATA_W, user write data
- i_rd_en, input, 1, read request
- i_rd_addr, input, ADDR_W, read address
- o_dout, output, DATA_W, read data
- o_dout_vld, output, 1, o_dout valid strobe
- o_busy, output, 1, fill in progress
- o_init_done, output, 1, at least one fill has completed since reset; sticky
- o_wr_drop, output, 1, one-cycle pulse: user write discarded

## Operation
- FSM states: IDLE, FILL, READY.
- Reset: state = IDLE, fill counter = 0, mode and seed registers = 0. All outputs are 0. Memory contents are not reset.
- IDLE → FILL:
  - on the first cycle after reset release when AUTO_INIT=1, or
  - on i_init_start.
- READY → FILL on i_init_start.
- Start of a fill:
  - Latch i_init_mode and i_init_val on the start cycle. Later changes to these inputs do not affect the fill in progress.
  - Clear o_init_done only if the fill is re-entered from READY.
- FILL behaviour:
  - Write address cnt, cnt = 0 … 2**ADDR_W−1, one word per cycle.
  - Data = pattern(mode, cnt). Address is zero-extended to DATA_W, or truncated to DATA_W.
  - Seed + address is computed modulo 2**DATA_W.
- End of fill: after the write at cnt = max, go to READY, set o_init_done, clear cnt to 0. The counter must not wrap into a second pass.
- i_init_start during FILL is ignored.
- User writes:
  - Accepted only in READY.
  - i_wr_en in IDLE or FILL is discarded and o_wr_drop pulses for one cycle.
- Reads:
  - Accepted in any state.
  - Same-cycle read and write (fill or user) to the same address returns the old data (read-first).
- Reset asserted mid-fill: abort immediately; state = IDLE. Partially written memory is left as is. If AUTO_INIT=1, a new fill starts from 0 after release.

## Timing
- Fill length: exactly 2**ADDR_W cycles.
  - o_busy is high from the cycle after the start event through the last write cycle.
  - o_init_done rises on the cycle after the last write. Example: ADDR_W=10 gives 1024 busy cycles.
- Read latency:
  - i_rd_en sampled at edge N → o_dout and o_dout_vld at edge N+RD_LAT.
  - o_dout_vld is a pure RD_LAT-deep shift of i_rd_en.
  - Back-to-back reads give full throughput.
- o_dout holds its last value when o_dout_vld = 0.
- First user write: a write is accepted in the cycle after o_busy falls. Its data is readable by a read issued one cycle later.

## Structure
- Shared package sdp_ram_pkg holds:
  - init-mode encodings (INIT_ADDR, INIT_CONST, INIT_SEED, INIT_ZERO),
  - FSM state encodings,
  - RD_LAT legality check constant.
- Sub-module sdp_ram_core: inferred memory array plus RD_LAT output pipeline. It contains no reset on the memory array; only its output and valid registers are reset.
- The top level contains the FSM, fill counter, pattern mux and write-port arbitration.
- Elaboration error when RD_LAT ∉ {1,2} or DATA_W < 8.

## Test plan
- Auto-init, mode 0, ADDR_W=10:
  - Release reset → o_busy high for 1024 cycles, then o_init_done = 1.
  - Read addresses 0, 5, 1023 → 0, 5, 1023 after RD_LAT cycles.
- Re-init, mode 2, seed 0xFFFF_FFFE: pulse i_init_start in READY → address 1 reads 0xFFFF_FFFF and address 3 reads 0x0000_0001 (wrap).
- User write during FILL (addr 7, data 0xA5):
  - o_wr_drop pulses; data is discarded.
  - After the fill, mode-1 constant 0x1234 is read at address 7.
  - The same write in READY → reads 0xA5.
- Same-cycle read and write to address 20 in READY → returns old data; the next read returns new data. Check with both RD_LAT=1 and RD_LAT=2.
- Reset asserted at fill cycle 300 (AUTO_INIT=1):
  - All outputs are 0 during reset.
  - After release the fill restarts at address 0; o_init_done comes 1024 cycles later.
